sram16k_wb_bridge: RTL
======================

SRAM16K_WB_BRIDGE -- requirements
Module: sram16k_wb_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: byte base of the 16 KB window; bits [13:0] are zero.
REQ-002 SHALL have port clk, input, 1: single clock for the block and the attached SRAM16K.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port wb_cyc_i, input, 1: Wishbone classic cycle.
REQ-005 SHALL have port wb_stb_i, input, 1: strobe.
REQ-006 SHALL have port wb_we_i, input, 1: 1 = write.
REQ-007 SHALL have port wb_sel_i, input, 4: byte lanes.
REQ-008 SHALL have port wb_adr_i, input, 32: byte address.
REQ-009 SHALL have port wb_dat_i, input, 32: write data.
REQ-010 SHALL have port wb_dat_o, output, 32: registered read data.
REQ-011 SHALL have port wb_ack_o, output, 1: registered acknowledge.
REQ-012 SHALL have port wb_err_o, output, 1: registered error (see Configuration).
REQ-013 SHALL have port sram_addr, output, 12: word address, equal to wb_adr_i[13:2] as captured.
REQ-014 SHALL have port sram_wdata, output, 32: write data.
REQ-015 SHALL have port sram_rdata, input, 32: SRAM read data, valid the cycle after the capturing edge.
REQ-016 SHALL have port sram_cs, output, 1: active-high chip select.
REQ-017 SHALL have port sram_wen, output, 4: per-byte write enable; all-zero = read.

Function
REQ-018 A request (hit) is wb_cyc_i & wb_stb_i & (wb_adr_i[31:14] == BASE_ADDR[31:14]) sampled at a clk edge in IDLE.
REQ-019 FSM states SHALL be IDLE, ACCESS, RDWAIT, ACK, ERR.
REQ-020 IDLE -> ACCESS on a hit. The same edge captures addr[13:2], dat_i, sel and we into holding registers.
REQ-021 In ACCESS, sram_cs SHALL be 1 and sram_wen = we ? sel : 4'b0. Exception: for a write with sel == 4'b0, sram_cs SHALL be 0.
REQ-022 ACCESS -> ACK for writes and RDWAIT for reads.
REQ-023 RDWAIT SHALL load wb_dat_o from sram_rdata at its exit edge, then go to ACK.
REQ-024 ACK SHALL hold wb_ack_o = 1 for exactly one cycle, then go to IDLE.
REQ-025 Latency, counted from the request edge E0: write ack high in the cycle after E1; read ack high in the cycle after E2.
REQ-026 Outside ACCESS, sram_cs SHALL be 0 and sram_wen SHALL be 0.
REQ-027 sram_addr and sram_wdata SHALL come only from the holding registers.
REQ-028 wb_dat_o SHALL hold its value until the next read completes; it is unchanged by writes.
REQ-029 If wb_cyc_i is 0 in ACCESS or RDWAIT, the FSM SHALL return to IDLE at the next edge with no ack. sram_cs SHALL be forced to 0 in that cycle.
REQ-030 A hit sampled in the cycle immediately after ACK SHALL start a new transaction; back-to-back throughput is one request per 3 (write) or 4 (read) cycles.

Reset
REQ-031 While rst_n = 0, the state SHALL be IDLE and all outputs and holding registers SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no ack or err afterwards.

Configuration
REQ-033 Macro SRAM16K_BRIDGE_ERR_EN selects error signalling for out-of-window requests.
REQ-034 With SRAM16K_BRIDGE_ERR_EN defined: cyc & stb with an address miss in IDLE -> ERR. ERR drives wb_err_o = 1 for one cycle, makes no SRAM access, then returns to IDLE.
REQ-035 Without SRAM16K_BRIDGE_ERR_EN: misses SHALL be ignored and wb_err_o SHALL be tied to 0. The ERR state SHALL be absent.

Verification
REQ-036 Write 0x3000_0010, dat 0xDEADBEEF, sel 4'hF -> one cycle with sram_cs=1, sram_addr=12'h004, sram_wen=4'hF; ack in the cycle after E1.
REQ-037 Read 0x3000_0010 with SRAM model returning 0xDEADBEEF -> wb_dat_o=0xDEADBEEF and ack in the cycle after E2; sram_wen=0 during ACCESS.
REQ-038 Write with sel 4'b0101 to 0x3000_3FFC -> sram_addr=12'hFFF, sram_wen=4'b0101. Write with sel 4'b0 -> sram_cs stays 0 and ack is still returned.
REQ-039 Read request, then wb_cyc_i dropped in RDWAIT -> no ack, FSM back in IDLE, wb_dat_o unchanged.
REQ-040 With ERR_EN, access to 0x3000_4000 -> wb_err_o=1 one cycle after the request edge and sram_cs never 1. Without ERR_EN, the same access -> no response for 10 cycles.
REQ-041 rst_n pulsed low during ACCESS of a write -> sram_cs=0 immediately, then no ack and all outputs 0.

Source files
------------

// File: rtl/sram16k_wb_bridge.sv
// Wishbone classic slave that maps a 16 KB window at BASE_ADDR onto a single-port SRAM16K.
// Define SRAM16K_BRIDGE_ERR_EN to answer out-of-window requests with a one-cycle wb_err_o.
module sram16k_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [11:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_cs,
  output logic [3:0]  sram_wen
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RDWAIT = 3'd2,
    ACK    = 3'd3
`ifdef SRAM16K_BRIDGE_ERR_EN
    , ERR  = 3'd4
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        req_s, hit_s, unused_s;

  assign req_s    = wb_cyc_i & wb_stb_i;
  assign hit_s    = req_s & (wb_adr_i[31:14] == BASE_ADDR[31:14]);
  // Byte offset within the word is meaningless to a 32-bit SRAM; lanes come from wb_sel_i.
  assign unused_s = ^wb_adr_i[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped cycle abandons the access without an ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          state_d = ACCESS;
        end
`ifdef SRAM16K_BRIDGE_ERR_EN
        else if (req_s) begin
          state_d = ERR;
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (we_q) begin
          state_d = ACK;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
`ifdef SRAM16K_BRIDGE_ERR_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: SRAM strobes, holding-register capture and registered response inputs.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    we_d     = we_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    sram_cs  = 1'b0;
    sram_wen = 4'b0000;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          addr_d  = wb_adr_i[13:2];
          wdata_d = wb_dat_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
        end else begin
`ifdef SRAM16K_BRIDGE_ERR_EN
          err_d = req_s;
`else
          err_d = 1'b0;
`endif
        end
      end
      ACCESS: begin
        // A write with no lanes selected still completes but never touches the array.
        sram_cs  = wb_cyc_i & ~(we_q & (sel_q == 4'b0000));
        sram_wen = we_q ? sel_q : 4'b0000;
        ack_d    = wb_cyc_i & we_q;
      end
      RDWAIT: begin
        if (wb_cyc_i) begin
          ack_d = 1'b1;
          dat_d = sram_rdata;
        end else begin
          ack_d = 1'b0;
        end
      end
      default: begin
        ack_d = 1'b0;
      end
    endcase
  end

  // Holding registers and registered Wishbone responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 12'h000;
      wdata_q <= 32'h0000_0000;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      dat_q   <= 32'h0000_0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
